regfile_dump_reader: RTL and testbench

- Sequential reader that sweeps a contiguous, wrap-around range of CPU register-file entries through one read port.
- Streams each {address, data} pair out over a valid/ready interface, for debug dump, scan-out and testbench golden-compare.
- Snoops the register-file write port and flags any dumped value that was overwritten during the sweep.
- Sits beside the register file, sharing one read port with the datapath via an external mux selected by busy.

---
 rtl/regfile_dump_reader.sv | 137 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader.
// Sweeps a wrap-around range of register-file entries through one read port,
// streams {address, data} beats over valid/ready, accumulates a checksum of
// accepted data and snoops the write port to flag values overwritten after
// they were captured.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; checksum/stale from last sweep readable
// LOAD   | read port driven with ptr; rd captured into the beat at the edge
// SEND   | beat presented, held stable until out_ready
// DONE   | one-cycle done pulse, read port released
module regfile_dump_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic              stale
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_last_addr;
    logic [NUM_REGS-1:0] r_mask;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_out_addr;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic [DATA_W-1:0]   r_checksum;
    logic                r_stale;

    logic                w_busy;
    logic [ADDR_W-1:0]   w_ptr_next;
    logic                w_stale_hit;

    // Read-port control, status decode, wrap-around pointer and write snoop.
    // A write landing on the entry being captured in LOAD counts as stale:
    // the capture takes the pre-write value.
    always_comb begin
        w_busy      = (r_state == S_LOAD) || (r_state == S_SEND);
        w_ptr_next  = (r_ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
        w_stale_hit = w_busy && wr_en &&
                      (r_mask[wr_addr] || ((r_state == S_LOAD) && (wr_addr == r_ptr)));
    end

    assign ra        = (r_state == S_LOAD) ? r_ptr : '0;
    assign busy      = w_busy;
    assign done      = (r_state == S_DONE);
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign checksum  = r_checksum;
    assign stale     = r_stale;

    // Sweep sequencer, beat capture/handshake, checksum and stale tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_last_addr <= '0;
            r_mask      <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_checksum  <= '0;
            r_stale     <= 1'b0;
        end else begin
            if (w_stale_hit) begin
                r_stale <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ptr       <= first_addr;
                        r_last_addr <= last_addr;
                        r_checksum  <= '0;
                        r_stale     <= 1'b0;
                        r_mask      <= '0;
                        r_state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_out_data     <= rd;
                    r_out_addr     <= r_ptr;
                    r_out_valid    <= 1'b1;
                    r_out_last     <= (r_ptr == r_last_addr);
                    r_mask[r_ptr]  <= 1'b1;
                    r_state        <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready) begin
                        r_checksum  <= r_checksum + r_out_data;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        if (r_out_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_ptr   <= w_ptr_next;
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected beats are queued when a
// sweep is issued, a monitor pops and compares each accepted beat.
module tb_regfile_dump_reader;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic          stale;

    always #5 clk = ~clk;

    regfile_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .rst(rst), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .ra(ra), .rd(rd), .wr_en(wr_en), .wr_addr(wr_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .checksum(checksum), .stale(stale)
    );

    // register-file model: combinational read, writes land just after the edge
    logic [DW-1:0] regs [NR];
    assign rd = regs[ra];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         exp_q[$];
    int            acc_cyc[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    int            acc_cnt = 0;
    int            ready_mode = 0;
    int            stall_addr = 0;
    int            stall_left = 0;
    int            t0 = 0;
    int            done_cyc = 0;
    int            exp_cnt = 0;
    logic [DW-1:0] exp_sum;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic int span(input int f, input int l);
        return (((l - f) % NR) + NR) % NR + 1;
    endfunction

    function automatic bit in_range(input int a, input int f, input int l);
        return (((a - f) % NR + NR) % NR) < span(f, l);
    endfunction

    // ready driver + monitor, one process so ready and its sampling agree
    initial begin
        beat_t         e;
        logic          pv;
        logic          pr;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          pl;
        pv = 1'b0; pr = 1'b1; pa = '0; pd = '0; pl = 1'b0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_mode == 0) begin
                out_ready = 1'b1;
            end else if (ready_mode == 1) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else if (out_valid && (int'(out_addr) == stall_addr) && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv && !pr) begin
                    chk("hold_valid", 64'(out_valid), 64'(1));
                    chk("hold_addr", 64'(out_addr), 64'(pa));
                    chk("hold_data", 64'(out_data), 64'(pd));
                    chk("hold_last", 64'(out_last), 64'(pl));
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got addr %0d data %0d, expected no beat", out_addr, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_addr", 64'(out_addr), 64'(e.a));
                        chk("beat_data", 64'(out_data), 64'(e.d));
                        chk("beat_last", 64'(out_last), 64'(e.l));
                    end
                    acc_cnt++;
                    acc_cyc.push_back(cyc);
                end
                pv = out_valid; pr = out_ready; pa = out_addr; pd = out_data; pl = out_last;
            end
        end
    end

    task automatic write_reg(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        @(posedge clk);
        #1 regs[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // queue the expected beats from the register image, then pulse start
    task automatic start_sweep(input int f, input int l, input bit ov, input int ova, input logic [DW-1:0] ovd);
        int    n;
        beat_t b;
        n = span(f, l);
        exp_sum = '0;
        exp_cnt = n;
        acc_cnt = 0;
        acc_cyc.delete();
        for (int k = 0; k < n; k++) begin
            b.a = AW'((f + k) % NR);
            b.d = (ov && ((f + k) % NR) == ova) ? ovd : regs[(f + k) % NR];
            b.l = (k == n - 1);
            exp_q.push_back(b);
            exp_sum = exp_sum + b.d;
        end
        @(negedge clk);
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_sweep(input logic exp_stale, input string tag);
        int dc;
        dc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        n_tests++;
        if (dc < 0) begin
            n_fail++;
            $display("FAIL %s.done_timeout: got no done, expected done within 1000 cycles", tag);
        end
        done_cyc = dc;
        @(negedge clk);
        chk({tag, ".done_width"}, 64'(done), 64'(0));
        chk({tag, ".busy_idle"}, 64'(busy), 64'(0));
        chk({tag, ".checksum"}, 64'(checksum), 64'(exp_sum));
        chk({tag, ".stale"}, 64'(stale), 64'(exp_stale));
        chk({tag, ".beats"}, 64'(acc_cnt), 64'(exp_cnt));
        chk({tag, ".queue_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic load_0_3();
        regs[0] = 32'd10; regs[1] = 32'd20; regs[2] = 32'd30; regs[3] = 32'd40;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0;
        wr_en = 1'b0; wr_addr = '0;
        for (int i = 0; i < NR; i++) regs[i] = DW'(i * 3 + 1);
        repeat (2) @(negedge clk);
        chk("rst.out_valid", 64'(out_valid), 64'(0));
        chk("rst.busy", 64'(busy), 64'(0));
        chk("rst.done", 64'(done), 64'(0));
        chk("rst.checksum", 64'(checksum), 64'(0));
        chk("rst.stale", 64'(stale), 64'(0));
        chk("rst.ra", 64'(ra), 64'(0));
        chk("rst.out_last", 64'(out_last), 64'(0));
        chk("rst.out_data", 64'(out_data), 64'(0));
        rst = 1'b0;

        // full-rate sweep 0..3
        load_0_3();
        start_sweep(0, 3, 0, 0, '0);
        finish_sweep(1'b0, "full");
        for (int k = 0; k < 4; k++)
            chk("full.beat_cycle", 64'((k < acc_cyc.size()) ? acc_cyc[k] - t0 : -1), 64'(2 + 2 * k));
        chk("full.done_cycle", 64'(done_cyc - t0), 64'(9));
        chk("full.checksum100", 64'(checksum), 64'(100));

        // backpressure on beat at address 1 for 3 cycles
        ready_mode = 2; stall_addr = 1; stall_left = 3;
        start_sweep(0, 3, 0, 0, '0);
        finish_sweep(1'b0, "bp");
        chk("bp.beat1_cycle", 64'((acc_cyc.size() > 1) ? acc_cyc[1] - t0 : -1), 64'(7));
        chk("bp.done_cycle", 64'(done_cyc - t0), 64'(12));
        ready_mode = 0;

        // wrap-around
        regs[30] = 32'd7; regs[31] = 32'd8; regs[0] = 32'd9; regs[1] = 32'd10;
        start_sweep(30, 1, 0, 0, '0);
        finish_sweep(1'b0, "wrap");
        chk("wrap.checksum34", 64'(checksum), 64'(34));
        start_sweep(5, 4, 0, 0, '0);
        finish_sweep(1'b0, "full_range");
        chk("full_range.count32", 64'(acc_cnt), 64'(32));

        // stale: r1 rewritten after it was dumped
        load_0_3();
        start_sweep(0, 3, 0, 0, '0);
        fork
            finish_sweep(1'b1, "stale_a");
            begin
                for (int i = 0; i < 50; i++) begin
                    if (acc_cnt >= 2) break;
                    @(negedge clk);
                end
                write_reg(1, 32'd99);
            end
        join

        // no stale: r3 rewritten before it is loaded, new value dumped
        load_0_3();
        start_sweep(0, 3, 1, 3, 32'd77);
        fork
            finish_sweep(1'b0, "stale_b");
            write_reg(3, 32'd77);
        join

        // start pulses during SEND and DONE are ignored
        load_0_3();
        start_sweep(0, 3, 0, 0, '0);
        fork
            finish_sweep(1'b0, "ign");
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                first_addr = AW'(10); last_addr = AW'(20); start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    if (done) break;
                    @(negedge clk);
                end
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        chk("ign.busy_after", 64'(busy), 64'(0));
        chk("ign.no_extra_beats", 64'(acc_cnt), 64'(4));

        // reset mid-sweep with a beat pending and stale set
        load_0_3();
        start_sweep(0, 3, 0, 0, '0);
        for (int i = 0; i < 50; i++) begin
            if (acc_cnt >= 1) break;
            @(negedge clk);
        end
        write_reg(0, 32'd55);
        for (int i = 0; i < 20; i++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        chk("rst_mid.pre_stale", 64'(stale), 64'(1));
        chk("rst_mid.pre_checksum", 64'(checksum), 64'(10));
        chk("rst_mid.pre_valid", 64'(out_valid), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        chk("rst_mid.out_valid", 64'(out_valid), 64'(0));
        chk("rst_mid.busy", 64'(busy), 64'(0));
        chk("rst_mid.checksum", 64'(checksum), 64'(0));
        chk("rst_mid.stale", 64'(stale), 64'(0));
        chk("rst_mid.done", 64'(done), 64'(0));
        load_0_3();
        start_sweep(0, 3, 0, 0, '0);
        finish_sweep(1'b0, "after_rst");

        // randomized sweeps with random backpressure and unrelated writes
        for (int it = 0; it < 15; it++) begin
            int f;
            int l;
            for (int i = 0; i < NR; i++) regs[i] = $urandom;
            f = $urandom_range(0, NR - 1);
            l = $urandom_range(0, NR - 1);
            ready_mode = $urandom_range(0, 1);
            start_sweep(f, l, 0, 0, '0);
            fork
                finish_sweep(1'b0, "rand");
                begin
                    for (int w = 0; w < 3; w++) begin
                        int a;
                        repeat ($urandom_range(0, 10)) @(negedge clk);
                        a = $urandom_range(0, NR - 1);
                        if (!in_range(a, f, l)) write_reg(a, $urandom);
                    end
                end
            join
        end
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
